// File: rtl/iq_symbol_slicer_pkg.sv
// rtl/iq_symbol_slicer_pkg.sv - lock FSM encoding, bit mapping and saturating magnitude
package iq_symbol_slicer_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } lock_state_e;

   // Each bit is the sign of an integrated component; zero slices as positive.
   localparam logic BIT_POS = 1'b0;
   localparam logic BIT_NEG = 1'b1;
   localparam logic BPSK_B1 = 1'b0;

   function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
      logic signed [31:0] lim;
      logic signed [31:0] mag;
      lim = (32'sd1 <<< (w - 1)) - 32'sd1;
      mag = (x < 0) ? -x : x;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/iq_symbol_slicer_if.sv
// rtl/iq_symbol_slicer_if.sv - baseband sample input and sliced-bit output bundle
// SLICER_SOFT_OUT_EN adds the soft_I/soft_Q outputs.
interface iq_symbol_slicer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                         enable;
   logic                         is_bpsk;
   logic signed [DATA_WIDTH-1:0] I_data;
   logic signed [DATA_WIDTH-1:0] Q_data;
   logic                         I_valid;
   logic                         Q_valid;
   logic                         sym_sync;
   logic [1:0]                   bits_tdata;
   logic                         bits_tvalid;
   logic                         bits_tready;
   logic                         bits_is_bpsk;
   logic                         locked;
   logic                         overflow;
`ifdef SLICER_SOFT_OUT_EN
   logic signed [DATA_WIDTH-1:0] soft_I;
   logic signed [DATA_WIDTH-1:0] soft_Q;
`endif

   modport master (
      output enable, is_bpsk, I_data, Q_data, I_valid, Q_valid, sym_sync, bits_tready,
      input  bits_tdata, bits_tvalid, bits_is_bpsk, locked, overflow
`ifdef SLICER_SOFT_OUT_EN
      , input soft_I, soft_Q
`endif
   );

   modport slave (
      input  enable, is_bpsk, I_data, Q_data, I_valid, Q_valid, sym_sync, bits_tready,
      output bits_tdata, bits_tvalid, bits_is_bpsk, locked, overflow
`ifdef SLICER_SOFT_OUT_EN
      , output soft_I, soft_Q
`endif
   );

endinterface

// File: rtl/iq_symbol_slicer_lock_fsm.sv
// rtl/iq_symbol_slicer_lock_fsm.sv - carrier lock detector stepped once per sliced symbol
module slicer_lock_fsm
   import iq_symbol_slicer_pkg::*;
#(
   parameter int LOCK_COUNT = 32,
   parameter int LOSS_COUNT = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic good_i,
   input  logic mode_change_i,
   output logic locked_o
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_COUNT + 1);

   lock_state_e       state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [MISS_W-1:0] miss_q, miss_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_SEARCH;
         run_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         miss_q  <= miss_d;
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      miss_d  = miss_q;
      // A mode switch invalidates whatever the metric says on the same edge.
      if (mode_change_i) begin
         state_d = ST_SEARCH;
         run_d   = '0;
         miss_d  = '0;
      end else if (valid_i) begin
         case (state_q)
            ST_SEARCH: begin
               if (good_i) begin
                  run_d   = RUN_W'(1);
                  miss_d  = '0;
                  state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (good_i) begin
                  run_d = run_q + RUN_W'(1);
                  if (run_d == RUN_W'(LOCK_COUNT)) begin
                     state_d = ST_LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  state_d = ST_SEARCH;
                  run_d   = '0;
               end
            end
            ST_LOCKED: begin
               if (good_i) begin
                  miss_d = '0;
               end else begin
                  miss_d = miss_q + MISS_W'(1);
                  if (miss_d == MISS_W'(LOSS_COUNT)) begin
                     state_d = ST_SEARCH;
                     run_d   = '0;
                     miss_d  = '0;
                  end
               end
            end
            default: begin
               state_d = ST_SEARCH;
               run_d   = '0;
               miss_d  = '0;
            end
         endcase
      end
   end

   assign locked_o = (state_q == ST_LOCKED);

endmodule

// File: rtl/iq_symbol_slicer.sv
// rtl/iq_symbol_slicer.sv - integrate-and-dump BPSK/QPSK hard slicer with lock detect
// SLICER_SOFT_OUT_EN adds registered soft_I/soft_Q outputs.
module iq_symbol_slicer
   import iq_symbol_slicer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SPS        = 16,
   parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(SPS),
   parameter int MAG_MIN    = 1024,
   parameter int LOCK_COUNT = 32,
   parameter int LOSS_COUNT = 8
) (
   input logic               clk_32M768,
   input logic               rst_32M768,
   iq_symbol_slicer_if.slave bus
);

   localparam int               CNT_W    = $clog2(SPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
   localparam int unsigned      DW       = DATA_WIDTH;

   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0] acc_I_q, acc_I_d, acc_Q_q, acc_Q_d;
   logic signed [ACC_WIDTH-1:0] sum_I, sum_Q;
   // Only the top DATA_WIDTH bits of a dump are ever consumed, so only those are kept.
   logic [DATA_WIDTH-1:0]       dump_I_q, dump_I_d, dump_Q_q, dump_Q_d;
   logic                        dump_bpsk_q, dump_bpsk_d, dump_vld_q;
   logic                        accept, dump;

   logic [1:0] tdata_q, tdata_d, bits_new;
   logic       tvalid_q, tvalid_d, out_bpsk_q, out_bpsk_d, ovf_q, ovf_d, load;
   logic       is_bpsk_q, mode_change;

   logic [31:0] m_I, m_Q, m_sum, m_diff;
   logic        good_bpsk, good_qpsk, good;

   assign accept = bus.enable & bus.I_valid & bus.Q_valid;
   assign dump   = accept & ((cnt_q == CNT_LAST) | bus.sym_sync);
   assign sum_I  = acc_I_q + {{(ACC_WIDTH-DATA_WIDTH){bus.I_data[DATA_WIDTH-1]}}, bus.I_data};
   assign sum_Q  = acc_Q_q + {{(ACC_WIDTH-DATA_WIDTH){bus.Q_data[DATA_WIDTH-1]}}, bus.Q_data};

   always_comb begin
      cnt_d       = cnt_q;
      acc_I_d     = acc_I_q;
      acc_Q_d     = acc_Q_q;
      dump_I_d    = dump_I_q;
      dump_Q_d    = dump_Q_q;
      dump_bpsk_d = dump_bpsk_q;
      if (dump) begin
         cnt_d       = '0;
         acc_I_d     = '0;
         acc_Q_d     = '0;
         dump_I_d    = sum_I[ACC_WIDTH-1 -: DATA_WIDTH];
         dump_Q_d    = sum_Q[ACC_WIDTH-1 -: DATA_WIDTH];
         dump_bpsk_d = bus.is_bpsk;
      end else if (accept) begin
         cnt_d   = cnt_q + CNT_W'(1);
         acc_I_d = sum_I;
         acc_Q_d = sum_Q;
      end
   end

   assign bits_new = dump_bpsk_q
      ? {BPSK_B1, dump_I_q[DATA_WIDTH-1] ? BIT_NEG : BIT_POS}
      : {dump_I_q[DATA_WIDTH-1] ? BIT_NEG : BIT_POS, dump_Q_q[DATA_WIDTH-1] ? BIT_NEG : BIT_POS};

   assign load = dump_vld_q & (~tvalid_q | bus.bits_tready);

   always_comb begin
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      out_bpsk_d = out_bpsk_q;
      ovf_d      = dump_vld_q & tvalid_q & ~bus.bits_tready;
      if (load) begin
         tdata_d    = bits_new;
         tvalid_d   = 1'b1;
         out_bpsk_d = dump_bpsk_q;
      end else if (bus.bits_tready) begin
         tvalid_d = 1'b0;
      end
   end

   assign m_I       = sat_abs({{(32-DATA_WIDTH){dump_I_q[DATA_WIDTH-1]}}, dump_I_q}, DW);
   assign m_Q       = sat_abs({{(32-DATA_WIDTH){dump_Q_q[DATA_WIDTH-1]}}, dump_Q_q}, DW);
   assign m_sum     = m_I + m_Q;
   assign m_diff    = (m_I > m_Q) ? (m_I - m_Q) : (m_Q - m_I);
   assign good_bpsk = (m_I >= (m_Q << 1)) & (m_sum >= 32'(MAG_MIN));
   assign good_qpsk = (m_diff <= (m_sum >> 2)) & (m_sum >= 32'(MAG_MIN));
   assign good      = dump_bpsk_q ? good_bpsk : good_qpsk;
   assign mode_change = bus.is_bpsk ^ is_bpsk_q;

   always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
      if (rst_32M768) begin
         cnt_q       <= '0;
         acc_I_q     <= '0;
         acc_Q_q     <= '0;
         dump_I_q    <= '0;
         dump_Q_q    <= '0;
         dump_bpsk_q <= 1'b0;
         dump_vld_q  <= 1'b0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         out_bpsk_q  <= 1'b0;
         ovf_q       <= 1'b0;
         is_bpsk_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_I_q     <= acc_I_d;
         acc_Q_q     <= acc_Q_d;
         dump_I_q    <= dump_I_d;
         dump_Q_q    <= dump_Q_d;
         dump_bpsk_q <= dump_bpsk_d;
         dump_vld_q  <= dump;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         out_bpsk_q  <= out_bpsk_d;
         ovf_q       <= ovf_d;
         is_bpsk_q   <= bus.is_bpsk;
      end
   end

   slicer_lock_fsm #(
      .LOCK_COUNT (LOCK_COUNT),
      .LOSS_COUNT (LOSS_COUNT)
   ) u_lock_fsm (
      .clk_i         (clk_32M768),
      .rst_i         (rst_32M768),
      .valid_i       (dump_vld_q),
      .good_i        (good),
      .mode_change_i (mode_change),
      .locked_o      (bus.locked)
   );

`ifdef SLICER_SOFT_OUT_EN
   logic [DATA_WIDTH-1:0] soft_I_q, soft_Q_q;

   always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
      if (rst_32M768) begin
         soft_I_q <= '0;
         soft_Q_q <= '0;
      end else if (load) begin
         soft_I_q <= dump_I_q;
         soft_Q_q <= dump_Q_q;
      end
   end

   assign bus.soft_I = soft_I_q;
   assign bus.soft_Q = soft_Q_q;
`endif

   assign bus.bits_tdata   = tdata_q;
   assign bus.bits_tvalid  = tvalid_q;
   assign bus.bits_is_bpsk = out_bpsk_q;
   assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_iq_symbol_slicer.sv
// tb/tb_iq_symbol_slicer.sv - directed-vector bench for iq_symbol_slicer
module tb_iq_symbol_slicer;

   logic clk = 1'b0;
   logic rst;

   always #15 clk = ~clk;

   iq_symbol_slicer_if #(.DATA_WIDTH(16)) bus ();

   iq_symbol_slicer #(
      .DATA_WIDTH (16),
      .SPS        (16),
      .MAG_MIN    (1024),
      .LOCK_COUNT (32),
      .LOSS_COUNT (8)
   ) dut (
      .clk_32M768 (clk),
      .rst_32M768 (rst),
      .bus        (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One accepted sample every second clock, as at the 16.384 MHz enable rate.
   task automatic send_symbol(input int len, input logic signed [15:0] i_s,
                              input logic signed [15:0] q_s, input bit sync_last,
                              input bit chk_idle, input string tag);
      for (int n = 0; n < len; n++) begin
         bus.I_data   = i_s;
         bus.Q_data   = q_s;
         bus.I_valid  = 1'b1;
         bus.Q_valid  = 1'b1;
         bus.enable   = 1'b1;
         bus.sym_sync = sync_last && (n == len - 1);
         @(posedge clk); #1;
         bus.enable   = 1'b0;
         bus.sym_sync = 1'b0;
         @(posedge clk); #1;
         if (n < len - 1) begin
            check({tag, "_ovf_idle"}, 32'(bus.overflow), 32'd0);
            if (chk_idle) check({tag, "_tvalid_idle"}, 32'(bus.bits_tvalid), 32'd0);
         end
      end
   endtask

   task automatic check_out(input string tag, input logic [1:0] tdata, input logic mode,
                            input logic lck);
      check({tag, "_tvalid"}, 32'(bus.bits_tvalid), 32'd1);
      check({tag, "_tdata"}, 32'(bus.bits_tdata), 32'(tdata));
      check({tag, "_mode"}, 32'(bus.bits_is_bpsk), 32'(mode));
      check({tag, "_locked"}, 32'(bus.locked), 32'(lck));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_tdata"}, 32'(bus.bits_tdata), 32'd0);
      check({tag, "_tvalid"}, 32'(bus.bits_tvalid), 32'd0);
      check({tag, "_mode"}, 32'(bus.bits_is_bpsk), 32'd0);
      check({tag, "_locked"}, 32'(bus.locked), 32'd0);
      check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      bus.enable      = 1'b0;
      bus.is_bpsk     = 1'b1;
      bus.I_data      = '0;
      bus.Q_data      = '0;
      bus.I_valid     = 1'b0;
      bus.Q_valid     = 1'b0;
      bus.sym_sync    = 1'b0;
      bus.bits_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // BPSK, I=+2000: 00 every symbol, lock on the 32nd
      for (int s = 1; s <= 32; s++) begin
         send_symbol(16, 16'sd2000, 16'sd0, 1'b0, 1'b1, "bpsk");
         check_out("bpsk", 2'b00, 1'b1, s == 32);
      end

      // mode toggle while locked drops lock on the next edge
      bus.is_bpsk = 1'b0;
      @(posedge clk); #1;
      check("toggle_unlock", 32'(bus.locked), 32'd0);

      // QPSK, I=-1500 Q=+1500: 10, relock after 32
      for (int s = 1; s <= 32; s++) begin
         send_symbol(16, -16'sd1500, 16'sd1500, 1'b0, 1'b1, "qpsk");
         check_out("qpsk", 2'b10, 1'b0, s == 32);
      end

      // Q=0 makes every symbol bad: lock falls on the 8th
      for (int s = 1; s <= 8; s++) begin
         send_symbol(16, -16'sd1500, 16'sd0, 1'b0, 1'b1, "qloss");
         check_out("qloss", 2'b10, 1'b0, s < 8);
      end

      // early sym_sync: 6-sample symbol, then a full 16-sample one
      send_symbol(6, 16'sd1000, -16'sd1000, 1'b1, 1'b1, "sync6");
      check_out("sync6", 2'b01, 1'b0, 1'b0);
      send_symbol(16, -16'sd1000, -16'sd1000, 1'b0, 1'b1, "after_sync");
      check_out("after_sync", 2'b11, 1'b0, 1'b0);
      @(posedge clk); #1;

      // backpressure over three symbol periods
      bus.bits_tready = 1'b0;
      send_symbol(16, 16'sd1000, 16'sd1000, 1'b0, 1'b1, "bp_a");
      check_out("bp_a", 2'b00, 1'b0, 1'b0);
      check("bp_a_ovf", 32'(bus.overflow), 32'd0);
      send_symbol(16, -16'sd1000, -16'sd1000, 1'b0, 1'b0, "bp_b");
      check_out("bp_b", 2'b00, 1'b0, 1'b0);
      check("bp_b_ovf", 32'(bus.overflow), 32'd1);
      send_symbol(16, 16'sd1000, -16'sd1000, 1'b0, 1'b0, "bp_c");
      check_out("bp_c", 2'b00, 1'b0, 1'b0);
      check("bp_c_ovf", 32'(bus.overflow), 32'd1);
      bus.bits_tready = 1'b1;
      @(posedge clk); #1;
      check("bp_drain_tvalid", 32'(bus.bits_tvalid), 32'd0);
      check("bp_drain_ovf", 32'(bus.overflow), 32'd0);

      // held symbol plus a partial accumulation, then reset mid-symbol
      bus.bits_tready = 1'b0;
      send_symbol(16, -16'sd1000, -16'sd1000, 1'b0, 1'b1, "pre_rst");
      check_out("pre_rst", 2'b11, 1'b0, 1'b0);
      bus.is_bpsk = 1'b1;
      send_symbol(7, 16'sh8000, 16'sd0, 1'b0, 1'b0, "partial");
      #5;
      rst = 1'b1;
      #2;
      check_reset("mid_rst");
      @(posedge clk); #1;
      rst             = 1'b0;
      bus.bits_tready = 1'b1;

      // full-scale negative I: 01 after exactly 16 samples; saturated mI still locks
      for (int s = 1; s <= 32; s++) begin
         send_symbol(16, 16'sh8000, 16'sd0, 1'b0, 1'b1, "sat");
         check_out("sat", 2'b01, 1'b1, s == 32);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
